// File: rtl/keypad_scan_fsm.sv
// Matrix keypad scanner: one-cold column sweep, ghost rejection, whole-frame debounce, one-entry key buffer popped by next.
// Keys land one cycle after a frame's last sample; a full buffer drops keys and sets overflow. Auto-repeat: KEYPAD_SCAN_REPEAT_EN.
module keypad_scan_fsm #(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int DEBOUNCE    = 4,
  parameter int REPEAT_DLY  = 16,
  parameter int REPEAT_RATE = 4,
  localparam int KW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            next,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  output logic            overflow
);

  localparam int DW   = $clog2(SCAN_DIV);
  localparam int CIW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CW   = $clog2(DEBOUNCE + 1);

  if (ROWS < 1 || COLS < 1 || SCAN_DIV < 3 || DEBOUNCE < 1 || REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("keypad_scan_fsm: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  logic [ROWS-1:0] row_s1, row_s2;
  logic            run;
  logic [DW-1:0]   div_cnt;
  logic [CIW-1:0]  col_idx, col_nxt;
  logic [1:0]      acc_hits, col_hits, frame_hits;
  logic [KW-1:0]   acc_code, col_code, frame_code;
  logic            sample, frame_end, cand_vld;
  logic            emit;
  logic [KW-1:0]   emit_code;
  state_t          state;
  logic [KW-1:0]   code;
  logic [CW-1:0]   cnt;

`ifdef KEYPAD_SCAN_REPEAT_EN
  localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  // rep counts frames within the current phase: first the initial delay, then each repeat period
  logic [RW-1:0] rep;
  logic          rep_phase;
  logic          rep_hit;
  assign rep_hit = (rep == (rep_phase ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DLY - 1)));
`endif

  assign sample    = run && (div_cnt == DW'(SCAN_DIV - 1));
  assign frame_end = sample && (col_idx == CIW'(COLS - 1));
  assign col_nxt   = (col_idx == CIW'(COLS - 1)) ? '0 : col_idx + CIW'(1);
  assign cand_vld  = (frame_hits == 2'd1);

  // Pressed-bit tally saturates at 2 so any multi-key frame reads as "many"
  always_comb begin
    col_hits = 2'd0;
    col_code = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (!row_s2[r]) begin
        col_hits = (col_hits == 2'd0) ? 2'd1 : 2'd2;
        col_code = KW'(r * COLS) + KW'(col_idx);
      end
    end
    frame_hits = acc_hits;
    frame_code = acc_code;
    if (col_hits != 2'd0) begin
      frame_hits = (acc_hits == 2'd0) ? col_hits : 2'd2;
      frame_code = col_code;
    end
  end

  always_comb begin
    emit      = 1'b0;
    emit_code = code;
    if (frame_end && cand_vld) begin
      case (state)
        IDLE: begin
          emit      = (DEBOUNCE <= 1);
          emit_code = frame_code;
        end
        PRESS_DB: emit = (frame_code == code) && (cnt == CW'(DEBOUNCE - 1));
`ifdef KEYPAD_SCAN_REPEAT_EN
        HELD: emit = rep_hit;
`endif
        default: emit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1    <= '1;
      row_s2    <= '1;
      run       <= 1'b0;
      div_cnt   <= '0;
      col_idx   <= '0;
      col       <= '1;
      acc_hits  <= 2'd0;
      acc_code  <= '0;
      state     <= IDLE;
      code      <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      overflow  <= 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
      rep       <= '0;
      rep_phase <= 1'b0;
`endif
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;

      if (!run) begin
        run <= 1'b1;
        col <= ~COLS'(1);
      end else if (sample) begin
        div_cnt <= '0;
        col_idx <= col_nxt;
        col     <= ~(COLS'(1) << col_nxt);
        if (frame_end) begin
          acc_hits <= 2'd0;
          acc_code <= '0;
        end else begin
          acc_hits <= frame_hits;
          acc_code <= frame_code;
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end

      if (frame_end) begin
        case (state)
          IDLE: begin
            if (cand_vld) begin
              code <= frame_code;
              if (DEBOUNCE <= 1) begin
                state <= HELD;
                cnt   <= '0;
`ifdef KEYPAD_SCAN_REPEAT_EN
                rep       <= '0;
                rep_phase <= 1'b0;
`endif
              end else begin
                state <= PRESS_DB;
                cnt   <= CW'(1);
              end
            end
          end
          PRESS_DB: begin
            if (cand_vld && frame_code == code) begin
              if (cnt == CW'(DEBOUNCE - 1)) begin
                state <= HELD;
                cnt   <= '0;
`ifdef KEYPAD_SCAN_REPEAT_EN
                rep       <= '0;
                rep_phase <= 1'b0;
`endif
              end else begin
                cnt <= cnt + CW'(1);
              end
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          HELD: begin
            if (!cand_vld) begin
              state <= (DEBOUNCE <= 1) ? IDLE : REL_DB;
              cnt   <= (DEBOUNCE <= 1) ? '0 : CW'(1);
            end
`ifdef KEYPAD_SCAN_REPEAT_EN
            else if (rep_hit) begin
              rep       <= '0;
              rep_phase <= 1'b1;
            end else begin
              rep <= rep + RW'(1);
            end
`endif
          end
          REL_DB: begin
            if (!cand_vld) begin
              if (cnt == CW'(DEBOUNCE - 1)) begin
                state <= IDLE;
                cnt   <= '0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end else begin
              // Repeat counter is left untouched so a bounce back to HELD resumes it
              state <= (frame_code == code) ? HELD : IDLE;
              cnt   <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end

      if (emit && (!key_valid || next)) begin
        key_code  <= emit_code;
        key_valid <= 1'b1;
        overflow  <= 1'b0;
      end else if (emit) begin
        overflow <= 1'b1;
      end else if (next && key_valid) begin
        key_valid <= 1'b0;
        overflow  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_fsm.sv
// Bench for keypad_scan_fsm: frame-level keypad model compared every cycle, plus literal scenario checks.
module tb_keypad_scan_fsm;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int DIV   = 4;
  localparam int DEB   = 3;
  localparam int RDLY  = 4;
  localparam int RRATE = 2;

  localparam int WAITING   = 0;
  localparam int PRESSING  = 1;
  localparam int HOLDING   = 2;
  localparam int RELEASING = 3;

  logic            clk;
  logic            rst;
  logic            next;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] col;
  logic [3:0]      key_code;
  logic            key_valid;
  logic            overflow;

  logic [15:0]     keys;
  bit              auto_next;

  int checks;
  int errors;

  // reference state
  int         n;
  int         pq[$];
  int         mode;
  int         run_len;
  int         stored;
  int         held;
  logic       m_valid;
  logic       m_ovf;
  logic [3:0] m_code;
  logic [3:0] m_col;

  keypad_scan_fsm #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(DIV), .DEBOUNCE(DEB),
    .REPEAT_DLY(RDLY), .REPEAT_RATE(RRATE)
  ) dut (
    .clk(clk), .rst(rst), .next(next), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Physical keypad: a pressed key pulls its row low while its column is driven low
  always_comb begin
    row = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit frame_update(input int cand);
    bit e;
    e = 1'b0;
    case (mode)
      WAITING: if (cand >= 0) begin
        stored  = cand;
        run_len = 1;
        mode    = PRESSING;
      end
      PRESSING: if (cand == stored) begin
        run_len++;
        if (run_len == DEB) begin
          e    = 1'b1;
          mode = HOLDING;
          held = 0;
        end
      end else mode = WAITING;
      HOLDING: if (cand < 0) begin
        run_len = 1;
        mode    = RELEASING;
      end else begin
        held++;
`ifdef KEYPAD_SCAN_REPEAT_EN
        if (held == RDLY || (held > RDLY && (held - RDLY) % RRATE == 0)) e = 1'b1;
`endif
      end
      default: if (cand < 0) begin
        run_len++;
        if (run_len == DEB) mode = WAITING;
      end else mode = (cand == stored) ? HOLDING : WAITING;
    endcase
    return e;
  endfunction

  task automatic model_step();
    bit e;
    int sc;
    e = 1'b0;
    if (rst) begin
      n = 0; pq.delete(); mode = WAITING; run_len = 0; stored = 0; held = 0;
      m_valid = 1'b0; m_ovf = 1'b0; m_code = 4'd0; m_col = 4'hF;
      return;
    end
    n++;
    m_col = ~(COLS'(1) << (((n - 1) / DIV) % COLS));
    if (n > 1 && (n - 1) % DIV == 0) begin
      sc = ((n - 2) / DIV) % COLS;
      for (int r = 0; r < ROWS; r++)
        if (keys[r*COLS+sc]) pq.push_back(r*COLS+sc);
      if (sc == COLS - 1) begin
        e = frame_update(pq.size() == 1 ? pq[0] : -1);
        pq.delete();
      end
    end
    if (e && (!m_valid || next)) begin
      m_code = 4'(stored); m_valid = 1'b1; m_ovf = 1'b0;
    end else if (e) begin
      m_ovf = 1'b1;
    end else if (next && m_valid) begin
      m_valid = 1'b0; m_ovf = 1'b0;
    end
  endtask

  task automatic tick();
    if (auto_next) next = m_valid;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("col", 32'(col), 32'(m_col));
    chk("key_valid", 32'(key_valid), 32'(m_valid));
    chk("key_code", 32'(key_code), 32'(m_code));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic run_to_frame_end();
    do tick(); while ((n - 1) % (DIV * COLS) != 0);
  endtask

  task automatic frames(input int k);
    for (int i = 0; i < k; i++) run_to_frame_end();
  endtask

  task automatic pulse_next();
    next = 1'b1;
    tick();
    next = 1'b0;
  endtask

  task automatic do_reset(input logic [15:0] k);
    next = 1'b0;
    keys = k;
    rst  = 1'b1;
    tick();
    chk("rst_col", 32'(col), 32'hF);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    repeat (4) tick();
    rst = 1'b0;
    tick();
    chk("first_col", 32'(col), 32'hE);
  endtask

  initial begin
    logic [3:0] exp_col;
    checks = 0; errors = 0;
    auto_next = 1'b0;
    next = 1'b0; keys = '0; rst = 1'b1;

    // reset and scan order
    do_reset(16'h0000);
    repeat (3) tick();
    chk("col_dwell", 32'(col), 32'hE);
    for (int i = 0; i < 4; i++) begin
      repeat (4) tick();
      exp_col = ~(4'(1) << ((i + 1) % 4));
      chk("col_step", 32'(col), 32'(exp_col));
    end
    pulse_next();
    chk("next_when_empty", 32'(key_valid), 32'd0);
    frames(1);

    // single key row2/col1 -> code 9
    do_reset(16'h0200);
    frames(2);
    chk("single_before", 32'(key_valid), 32'd0);
    frames(1);
    chk("single_valid", 32'(key_valid), 32'd1);
    chk("single_code", 32'(key_code), 32'd9);
    pulse_next();
    chk("single_ack", 32'(key_valid), 32'd0);
    frames(2);
    chk("single_no_second", 32'(key_valid), 32'd0);

    // bounce on key 6, then a clean press proves the FSM is back to idle
    do_reset(16'h0040);
    frames(2);
    keys = 16'h0000;
    frames(3);
    chk("bounce_none", 32'(key_valid), 32'd0);
    keys = 16'h0040;
    frames(3);
    chk("after_bounce_valid", 32'(key_valid), 32'd1);
    chk("after_bounce_code", 32'(key_code), 32'd6);
    pulse_next();

    // ghost frames: diagonal, same column, same row
    do_reset(16'h0021);
    frames(6);
    chk("ghost_diag", 32'(key_valid), 32'd0);
    keys = 16'h0011;
    frames(4);
    chk("ghost_col", 32'(key_valid), 32'd0);
    keys = 16'h000C;
    frames(4);
    chk("ghost_row", 32'(key_valid), 32'd0);

    // overflow: key 3 buffered, key 12 dropped
    do_reset(16'h0008);
    frames(3);
    chk("ovf_first_code", 32'(key_code), 32'd3);
    keys = 16'h0000;
    frames(3);
    keys = 16'h1000;
    frames(3);
    chk("ovf_code_kept", 32'(key_code), 32'd3);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_valid", 32'(key_valid), 32'd1);
    pulse_next();
    chk("ovf_ack_valid", 32'(key_valid), 32'd0);
    chk("ovf_ack_flag", 32'(overflow), 32'd0);
    run_to_frame_end();

    // emit and next on the same edge: new code loads, no overflow
    keys = 16'h0000;
    frames(3);
    keys = 16'h0002;
    frames(3);
    chk("fill_code", 32'(key_code), 32'd1);
    keys = 16'h0000;
    frames(3);
    keys = 16'h1000;
    frames(2);
    while (n % (DIV * COLS) != 0) tick();
    pulse_next();
    chk("same_edge_valid", 32'(key_valid), 32'd1);
    chk("same_edge_code", 32'(key_code), 32'd12);
    chk("same_edge_ovf", 32'(overflow), 32'd0);

    // reset mid-frame drops the buffered key
    repeat (5) tick();
    do_reset(16'h0000);
    frames(1);

    // held key 7 for ten frames with prompt acknowledges
    do_reset(16'h0080);
    auto_next = 1'b1;
    for (int f = 1; f <= 10; f++) begin
      run_to_frame_end();
`ifdef KEYPAD_SCAN_REPEAT_EN
      chk("repeat_emit", 32'(key_valid), 32'(f == 3 || f == 7 || f == 9));
`else
      chk("repeat_emit", 32'(key_valid), 32'(f == 3));
`endif
      if (key_valid) chk("repeat_code", 32'(key_code), 32'd7);
    end
    auto_next = 1'b0;
    next = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan_fsm.md
# keypad_scan_fsm

- Parametrised matrix-keypad scanner that replaces the fixed 4x4 keypad state machine.
- Drives one column low at a time and samples the active-low rows.
- Rejects multi-key (ghost) frames and debounces presses and releases over whole scan frames.
- Presents each accepted key to the consumer through a one-entry buffer acknowledged by `next`.
- Sits between the board keypad pins and the input-handling logic of the top-level design.

## Interface
Parameters:
- ROWS, 4, number of keypad rows (>=1)
- COLS, 4, number of keypad columns (>=1)
- SCAN_DIV, 50000, clk cycles each column is driven (>=3)
- DEBOUNCE, 4, consecutive identical frames needed to accept a press or a release (>=1)
- REPEAT_DLY, 16, frames from acceptance to first auto-repeat (used only with repeat enabled)
- REPEAT_RATE, 4, frames between later auto-repeats (used only with repeat enabled)

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- next  in  1  consumer acknowledge; pops the key buffer when key_valid=1
- row  in  ROWS  row inputs, active-low, pulled up on board
- col  out  COLS  column drives, one-cold
- key_code  out  KW  code of the buffered key, where KW=max(1,$clog2(ROWS*COLS))
- key_valid  out  1  key buffer holds an unacknowledged key
- overflow  out  1  sticky flag: a key was dropped because the buffer was full

## Operation
- Column index c counts 0..COLS-1 and wraps to 0. col=~(1<<c).
- row passes through a 2-flop synchronizer. The synchronized row is sampled on the last dwell cycle of each column.
- A frame is one sweep of all columns. At the end of a frame:
  - Exactly one pressed bit in the frame: candidate = r*COLS+c.
  - Zero pressed bits, or two or more (ghost rejection): candidate = NONE.
- FSM, advanced once per frame end; cnt counts frames:
  - IDLE: if candidate != NONE, store code, cnt=1, go to PRESS_DB.
  - PRESS_DB: candidate equals the stored code gives cnt+1, and cnt reaching DEBOUNCE emits the key and goes to HELD. Any other candidate goes to IDLE.
  - HELD: candidate NONE gives cnt=1 and goes to REL_DB. Otherwise stay.
  - REL_DB: NONE gives cnt+1, and cnt reaching DEBOUNCE goes to IDLE. The stored code returns to HELD. A different key goes to IDLE.
- Emit behaviour:
  - Buffer empty: load key_code and set key_valid.
  - Buffer full: drop the new key, set overflow, leave key_code unchanged.
- next while key_valid=1 clears key_valid and overflow. next while key_valid=0 is ignored.
- Emit and next in the same cycle: load the new code, key_valid stays 1, no overflow.

## Timing
- Reset values:
  - col = all ones (no column driven)
  - key_code = 0, key_valid = 0, overflow = 0
  - state = IDLE, c = 0, all counters 0
- The first cycle after rst deasserts drives col=~1.
- Frame length is COLS*SCAN_DIV cycles.
- Emit latency: key_valid rises the cycle after the final sample edge of the DEBOUNCE-th matching frame.
- next takes effect on the next edge. key_valid is low the cycle after the acknowledging edge.
- rst asserted mid-frame or mid-debounce aborts immediately to the reset values. The buffered key is lost.
- All counters saturate or wrap only at their defined limits. The dwell counter and frame counters are sized by $clog2 of their limits.

## Configuration
- Macro: KEYPAD_SCAN_REPEAT_EN.
- Defined:
  - In HELD, a frame counter starts at 0 on entry and increments every frame.
  - The key is re-emitted when the counter reaches REPEAT_DLY, then every REPEAT_RATE frames after that.
  - Re-emits follow the same buffer and overflow rules as the first emit.
  - REL_DB pauses the counter. Returning to HELD resumes it.
- Undefined: exactly one emit per debounced press. No repeat logic is generated.

## Test plan
All scenarios use ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3, giving a 16-cycle frame.
- Reset and scan:
  - Stimulus: rst high for 5 cycles, then release.
  - Response: col=1111 and all outputs 0 during reset. After release col cycles 1110, 1101, 1011, 0111, each held 4 cycles, repeating.
- Single key, repeat off:
  - Stimulus: hold row2/col1 for 5 frames.
  - Response: key_valid rises at the end of the 3rd frame with key_code=9. A next pulse drops key_valid the following cycle. No second emit while held.
- Bounce:
  - Stimulus: key 6 present for 2 frames, then released.
  - Response: key_valid never asserts and the FSM returns to IDLE.
- Ghost rejection:
  - Stimulus: keys 0 and 5 held together for 6 frames.
  - Response: no emit.
- Overflow:
  - Stimulus: accept key 3, release for 3 frames, then accept key 12, with no next.
  - Response: key_code stays 3 and overflow=1. After next, key_valid=0 and overflow=0.
- Auto-repeat:
  - Stimulus: KEYPAD_SCAN_REPEAT_EN defined, REPEAT_DLY=4, REPEAT_RATE=2; hold key 7 for 10 frames, asserting next after each emit.
  - Response: emits with code 7 at the ends of frames 3, 7 and 9, and no others.
